uart_led_ctrl: RTL and testbench

ASCII command interpreter that sits inside the board core, directly downstream of the UART receiver and upstream of the UART transmitter. It consumes received bytes, drives the eight board LEDs and reports the debounced switch value back over the same link. It runs on the core clock, with the board's active-low reset applied asynchronously.

---
 rtl/uart_led_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_uart_led_ctrl.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_led_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : uart_led_ctrl
//  Purpose  : ASCII command interpreter between a UART RX and a UART TX.
//             Commands (case-insensitive):
//               L hh : load LEDs from two hex digits      -> "K"
//               S    : report switches as two hex digits  -> hh CR LF
//               R    : LEDs back to LED_RESET             -> "K"
//             CR, LF and space are ignored when no command is pending.
//             Any other byte is rejected with "?" and counted in err_count.
//  Ports    : clk, reset_n       core clock / asynchronous active-low reset
//             s_axis_*           received bytes (AXI-stream sink)
//             m_axis_*           response bytes (AXI-stream source)
//             sw                 debounced switches
//             led                registered LED drive
//             err_count          saturating count of rejected bytes
//  Revision : 1.0 - initial release
// ============================================================================
module uart_led_ctrl #(
    parameter logic [7:0] LED_RESET = 8'h00
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    input  logic [7:0] sw,
    output logic [7:0] led,
    output logic [7:0] err_count
);

    localparam logic [7:0] C_ASCII_K  = 8'h4B;
    localparam logic [7:0] C_ASCII_Q  = 8'h3F;
    localparam logic [7:0] C_ASCII_CR = 8'h0D;
    localparam logic [7:0] C_ASCII_LF = 8'h0A;
    localparam logic [7:0] C_ASCII_SP = 8'h20;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEX_HI = 2'd1,
        ST_HEX_LO = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [3:0][7:0] r_resp;
    logic [3:0][7:0] w_resp_nxt;
    logic [1:0]      r_idx;
    logic [1:0]      w_idx_nxt;
    logic [1:0]      r_len;       // index of the last response byte
    logic [1:0]      w_len_nxt;
    logic [3:0]      r_hi_nib;
    logic [3:0]      w_hi_nib_nxt;
    logic [7:0]      r_led;
    logic [7:0]      w_led_nxt;
    logic [7:0]      r_err;
    logic [7:0]      w_err_nxt;
    logic            r_s_ready;

    logic            w_s_fire;
    logic            w_m_fire;
    logic            w_rx_hex;
    logic [3:0]      w_rx_nib;
    logic            w_reject;

    function automatic logic is_hex(input logic [7:0] b);
        return (b >= 8'h30 && b <= 8'h39) ||
               (b >= 8'h41 && b <= 8'h46) ||
               (b >= 8'h61 && b <= 8'h66);
    endfunction

    // Letters A-F / a-f share the low nibble 1..6, so +9 gives 10..15.
    function automatic logic [3:0] hex_val(input logic [7:0] b);
        if (b <= 8'h39) begin
            return b[3:0];
        end
        return b[3:0] + 4'd9;
    endfunction

    function automatic logic [7:0] nib_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    assign w_s_fire = s_axis_tvalid & r_s_ready;
    assign w_m_fire = (r_state == ST_RESP) & m_axis_tready;
    assign w_rx_hex = is_hex(s_axis_tdata);
    assign w_rx_nib = hex_val(s_axis_tdata);

    always_comb begin
        w_state_nxt  = r_state;
        w_resp_nxt   = r_resp;
        w_idx_nxt    = r_idx;
        w_len_nxt    = r_len;
        w_hi_nib_nxt = r_hi_nib;
        w_led_nxt    = r_led;
        w_err_nxt    = r_err;
        w_reject     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_s_fire) begin
                    case (s_axis_tdata)
                        8'h4C, 8'h6C: begin
                            w_state_nxt = ST_HEX_HI;
                        end
                        8'h53, 8'h73: begin
                            // Byte 0 sits in the lowest lane.
                            w_resp_nxt  = {C_ASCII_LF, C_ASCII_CR,
                                           nib_ascii(sw[3:0]), nib_ascii(sw[7:4])};
                            w_len_nxt   = 2'd3;
                            w_state_nxt = ST_RESP;
                        end
                        8'h52, 8'h72: begin
                            w_led_nxt     = LED_RESET;
                            w_resp_nxt[0] = C_ASCII_K;
                            w_len_nxt     = 2'd0;
                            w_state_nxt   = ST_RESP;
                        end
                        C_ASCII_CR, C_ASCII_LF, C_ASCII_SP: begin
                            w_state_nxt = ST_IDLE;
                        end
                        default: begin
                            w_reject = 1'b1;
                        end
                    endcase
                end
            end
            ST_HEX_HI: begin
                if (w_s_fire) begin
                    if (w_rx_hex) begin
                        w_hi_nib_nxt = w_rx_nib;
                        w_state_nxt  = ST_HEX_LO;
                    end else begin
                        w_reject = 1'b1;
                    end
                end
            end
            ST_HEX_LO: begin
                if (w_s_fire) begin
                    if (w_rx_hex) begin
                        w_led_nxt     = {r_hi_nib, w_rx_nib};
                        w_resp_nxt[0] = C_ASCII_K;
                        w_len_nxt     = 2'd0;
                        w_state_nxt   = ST_RESP;
                    end else begin
                        w_reject = 1'b1;
                    end
                end
            end
            ST_RESP: begin
                if (w_m_fire) begin
                    if (r_idx == r_len) begin
                        w_state_nxt = ST_IDLE;
                        w_idx_nxt   = 2'd0;
                    end else begin
                        w_idx_nxt = r_idx + 2'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_reject) begin
            w_resp_nxt[0] = C_ASCII_Q;
            w_len_nxt     = 2'd0;
            w_state_nxt   = ST_RESP;
            if (r_err != 8'hFF) begin
                w_err_nxt = r_err + 8'd1;
            end
        end

        if (r_state != ST_RESP && w_state_nxt == ST_RESP) begin
            w_idx_nxt = 2'd0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_resp    <= '0;
            r_idx     <= 2'd0;
            r_len     <= 2'd0;
            r_hi_nib  <= 4'h0;
            r_led     <= LED_RESET;
            r_err     <= 8'h00;
            r_s_ready <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_resp    <= w_resp_nxt;
            r_idx     <= w_idx_nxt;
            r_len     <= w_len_nxt;
            r_hi_nib  <= w_hi_nib_nxt;
            r_led     <= w_led_nxt;
            r_err     <= w_err_nxt;
            // Ready follows the state being entered, so it drops right after
            // the byte that completes a command and returns with the final
            // response handshake.
            r_s_ready <= (w_state_nxt != ST_RESP);
        end
    end

    assign s_axis_tready = r_s_ready;
    assign m_axis_tvalid = (r_state == ST_RESP);
    assign m_axis_tdata  = r_resp[r_idx];
    assign led           = r_led;
    assign err_count     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_led_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_led_ctrl
//  Purpose  : Self-checking bench for uart_led_ctrl. A byte-stream model of
//             the command language predicts LED value, error count and the
//             response byte stream.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_led_ctrl;

    localparam logic [7:0] C_LED_RESET = 8'h5A;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic [7:0] s_axis_tdata = 8'h00;
    logic       s_axis_tvalid = 1'b0;
    logic       s_axis_tready;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tready = 1'b0;
    logic [7:0] sw = 8'h00;
    logic [7:0] led;
    logic [7:0] err_count;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    logic [7:0] pend[$];
    logic [7:0] m_led = C_LED_RESET;
    int         m_err = 0;
    bit         rand_rdy = 1'b0;

    uart_led_ctrl #(.LED_RESET(C_LED_RESET)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .sw            (sw),
        .led           (led),
        .err_count     (err_count)
    );

    always #5 clk = ~clk;

    // Record every completed TX handshake.
    always @(negedge clk) begin
        if (reset_n && m_axis_tvalid && m_axis_tready) got.push_back(m_axis_tdata);
    end

    always begin
        @(posedge clk);
        #1;
        if (rand_rdy) m_axis_tready = 1'($urandom_range(0, 1));
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic bit m_is_hex(input logic [7:0] b);
        return (b >= "0" && b <= "9") || (b >= "A" && b <= "F") || (b >= "a" && b <= "f");
    endfunction

    function automatic int m_hex_val(input logic [7:0] b);
        if (b <= "9") return int'(b) - 48;
        if (b <= "F") return int'(b) - 55;
        return int'(b) - 87;
    endfunction

    function automatic logic [7:0] m_hex_char(input int n);
        return (n < 10) ? 8'(48 + n) : 8'(55 + n);
    endfunction

    function automatic void m_bad();
        exp_q.push_back(8'h3F);
        if (m_err < 255) m_err++;
    endfunction

    function automatic void model_byte(input logic [7:0] b, input logic [7:0] swv);
        if (pend.size() == 0) begin
            if (b == "L" || b == "l") pend.push_back(b);
            else if (b == "S" || b == "s") begin
                exp_q.push_back(m_hex_char(int'(swv) / 16));
                exp_q.push_back(m_hex_char(int'(swv) % 16));
                exp_q.push_back(8'h0D);
                exp_q.push_back(8'h0A);
            end else if (b == "R" || b == "r") begin
                m_led = C_LED_RESET;
                exp_q.push_back(8'h4B);
            end else if (b == 8'h0D || b == 8'h0A || b == 8'h20) begin
                // ignored
            end else m_bad();
        end else if (!m_is_hex(b)) begin
            pend.delete();
            m_bad();
        end else if (pend.size() == 1) begin
            pend.push_back(b);
        end else begin
            m_led = 8'(m_hex_val(pend[1]) * 16 + m_hex_val(b));
            pend.delete();
            exp_q.push_back(8'h4B);
        end
    endfunction

    function automatic void model_reset();
        pend.delete();
        exp_q.delete();
        got.delete();
        m_led = C_LED_RESET;
        m_err = 0;
    endfunction

    // Index of the first differing TX byte, or -1 if the streams agree.
    function automatic int first_diff();
        int n;
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (got[i] !== exp_q[i]) return i;
        if (got.size() != exp_q.size()) return n;
        return -1;
    endfunction

    function automatic logic [7:0] got_at(input int i);
        return (i < got.size()) ? got[i] : 8'hxx;
    endfunction

    function automatic logic [7:0] exp_at(input int i);
        return (i < exp_q.size()) ? exp_q[i] : 8'hxx;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [7:0] b);
        int t = 0;
        s_axis_tdata  = b;
        s_axis_tvalid = 1'b1;
        @(negedge clk);
        while (!s_axis_tready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: byte %h tready %b want 1", b, s_axis_tready);
        end else begin
            model_byte(b, sw);
        end
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        @(negedge clk);
        while (!(s_axis_tready && !m_axis_tvalid) && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (t >= 400) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: tready %b tvalid %b want 1/0", s_axis_tready, m_axis_tvalid);
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] rand_hex();
        int n;
        n = $urandom_range(0, 15);
        if (n < 10) return 8'(48 + n);
        return ($urandom_range(0, 1) != 0) ? 8'(55 + n) : 8'(87 + n);
    endfunction

    function automatic logic [7:0] rand_case(input logic [7:0] c);
        return ($urandom_range(0, 1) != 0) ? c : (c | 8'h20);
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        m_axis_tready = 1'b1;
        #2 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL rst_s_tready: got %b want 0", s_axis_tready); end
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rst_m_tvalid: got %b want 0", m_axis_tvalid); end
        checks++; if (m_axis_tdata !== 8'h00) begin errors++; $display("FAIL rst_m_tdata: got %h want 00", m_axis_tdata); end
        checks++; if (led !== C_LED_RESET) begin errors++; $display("FAIL rst_led: got %h want %h", led, C_LED_RESET); end
        checks++; if (err_count !== 8'h00) begin errors++; $display("FAIL rst_err: got %h want 00", err_count); end
        reset_n = 1'b1;
        checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL rel_s_tready_early: got %b want 0", s_axis_tready); end
        @(posedge clk);
        #1;
        checks++; if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL rel_s_tready: got %b want 1", s_axis_tready); end
        model_reset();
    endtask

    task automatic test_load();
        int d;
        send("L"); send("3"); send("c");
        checks++; if (led !== 8'h3C) begin errors++; $display("FAIL load_led: got %h want 3c", led); end
        checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 8'h4B) begin
            errors++; $display("FAIL load_latency: tvalid %b data %h want 1/4b", m_axis_tvalid, m_axis_tdata); end
        checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL load_rx_bp: got %b want 0", s_axis_tready); end
        wait_idle();
        d = first_diff();
        checks++; if (d >= 0) begin errors++; $display("FAIL load_tx: byte %0d got %h want %h (n %0d/%0d)", d, got_at(d), exp_at(d), got.size(), exp_q.size()); end
        checks++; if (err_count !== 8'h00) begin errors++; $display("FAIL load_err: got %h want 00", err_count); end
        got.delete(); exp_q.delete();
    endtask

    task automatic test_switch();
        int d;
        int lowc = 0;
        sw = 8'hA5;
        send("s");
        sw = 8'h00;
        checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 8'h41) begin
            errors++; $display("FAIL sw_first: tvalid %b data %h want 1/41", m_axis_tvalid, m_axis_tdata); end
        while (!s_axis_tready && lowc < 20) begin
            lowc++;
            @(posedge clk);
            #1;
        end
        checks++; if (lowc != 4) begin errors++; $display("FAIL sw_rx_low_cycles: got %0d want 4", lowc); end
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL sw_tvalid_drop: got %b want 0", m_axis_tvalid); end
        d = first_diff();
        checks++; if (d >= 0 || got.size() != 4) begin errors++; $display("FAIL sw_tx: byte %0d got %h want %h (n %0d/4)", d, got_at(d), exp_at(d), got.size()); end
        got.delete(); exp_q.delete();
    endtask

    task automatic test_backpressure();
        int d;
        sw = 8'hA5;
        send("S");
        @(posedge clk);
        #1;
        m_axis_tready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 8'h35 || s_axis_tready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: tvalid %b data %h rx_ready %b want 1/35/0", i, m_axis_tvalid, m_axis_tdata, s_axis_tready);
            end
        end
        @(posedge clk);
        #1;
        m_axis_tready = 1'b1;
        wait_idle();
        d = first_diff();
        checks++; if (d >= 0 || got.size() != 4) begin errors++; $display("FAIL bp_tx: byte %0d got %h want %h (n %0d/4)", d, got_at(d), exp_at(d), got.size()); end
        got.delete(); exp_q.delete();
    endtask

    task automatic test_bad_hex();
        int d;
        send("L"); send("G");
        wait_idle();
        checks++; if (led !== 8'h3C) begin errors++; $display("FAIL badhex_led: got %h want 3c", led); end
        checks++; if (err_count !== 8'h01) begin errors++; $display("FAIL badhex_err: got %h want 01", err_count); end
        d = first_diff();
        checks++; if (d >= 0) begin errors++; $display("FAIL badhex_tx: byte %0d got %h want %h", d, got_at(d), exp_at(d)); end
        got.delete(); exp_q.delete();
        send("R");
        checks++; if (led !== C_LED_RESET) begin errors++; $display("FAIL r_led: got %h want %h", led, C_LED_RESET); end
        wait_idle();
        d = first_diff();
        checks++; if (d >= 0) begin errors++; $display("FAIL r_tx: byte %0d got %h want %h", d, got_at(d), exp_at(d)); end
        got.delete(); exp_q.delete();
    endtask

    task automatic test_saturation();
        int d;
        for (int i = 0; i < 300; i++) send(8'h7A);
        wait_idle();
        checks++; if (err_count !== 8'hFF) begin errors++; $display("FAIL sat_err: got %h want ff", err_count); end
        d = first_diff();
        checks++; if (d >= 0) begin errors++; $display("FAIL sat_tx: byte %0d got %h want %h (n %0d/%0d)", d, got_at(d), exp_at(d), got.size(), exp_q.size()); end
        got.delete(); exp_q.delete();
        send(8'h0D); send(8'h20);
        repeat (5) @(posedge clk);
        #1;
        checks++; if (got.size() != 0) begin errors++; $display("FAIL discard_tx: got %0d bytes want 0", got.size()); end
        checks++; if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL discard_ready: got %b want 1", s_axis_tready); end
        checks++; if (err_count !== 8'hFF) begin errors++; $display("FAIL discard_err: got %h want ff", err_count); end
    endtask

    task automatic test_random();
        int d;
        logic [7:0] bad [5];
        bad = '{8'h47, 8'h7A, 8'h0D, 8'h0A, 8'h2F};
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rand_rdy = 1'b1;
        for (int i = 0; i < 80; i++) begin
            sw = 8'($urandom);
            case ($urandom_range(0, 5))
                0: begin send(rand_case("L")); send(rand_hex()); send(rand_hex()); end
                1: begin
                    send(rand_case("L"));
                    if ($urandom_range(0, 1) != 0) send(rand_hex());
                    send(bad[$urandom_range(0, 4)]);
                end
                2: send(rand_case("S"));
                3: send(rand_case("R"));
                4: send(8'($urandom));
                default: send(bad[$urandom_range(2, 3)]);
            endcase
            checks++; if (led !== m_led) begin errors++; $display("FAIL rnd_led%0d: got %h want %h", i, led, m_led); end
            checks++; if (err_count !== m_err[7:0]) begin errors++; $display("FAIL rnd_err%0d: got %h want %h", i, err_count, m_err[7:0]); end
        end
        // Finish any half-sent L command with a rejected byte so the stream ends idle.
        send(8'h2F);
        rand_rdy = 1'b0;
        @(posedge clk);
        #2;
        m_axis_tready = 1'b1;
        wait_idle();
        d = first_diff();
        checks++; if (d >= 0) begin errors++; $display("FAIL rnd_tx: byte %0d got %h want %h (n %0d/%0d)", d, got_at(d), exp_at(d), got.size(), exp_q.size()); end
        got.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid();
        int d;
        send("L"); send("1"); send("2");
        wait_idle();
        got.delete(); exp_q.delete();
        sw = 8'h7E;
        send("S");
        @(posedge clk);
        #1;
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL mid_tvalid: got %b want 0", m_axis_tvalid); end
        checks++; if (m_axis_tdata !== 8'h00) begin errors++; $display("FAIL mid_tdata: got %h want 00", m_axis_tdata); end
        checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL mid_s_tready: got %b want 0", s_axis_tready); end
        checks++; if (led !== C_LED_RESET) begin errors++; $display("FAIL mid_led: got %h want %h", led, C_LED_RESET); end
        checks++; if (err_count !== 8'h00) begin errors++; $display("FAIL mid_err: got %h want 00", err_count); end
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        checks++; if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL mid_rel_ready: got %b want 1", s_axis_tready); end
        send("L"); send("9"); send("f");
        checks++; if (led !== 8'h9F) begin errors++; $display("FAIL mid_reload: got %h want 9f", led); end
        wait_idle();
        send("r");
        checks++; if (led !== C_LED_RESET) begin errors++; $display("FAIL mid_r_led: got %h want %h", led, C_LED_RESET); end
        wait_idle();
        d = first_diff();
        checks++; if (d >= 0 || got.size() != 2) begin errors++; $display("FAIL mid_tx: byte %0d got %h want %h (n %0d/2)", d, got_at(d), exp_at(d), got.size()); end
        got.delete(); exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_load();
        test_switch();
        test_backpressure();
        test_bad_hex();
        test_saturation();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
